// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control: fetch/decode/execute/memory/writeback sequencing with registered controls.
// Latency: R/I-ALU/sw 4 cycles, lw 5, branch/jump 3; no backpressure, one instruction in flight.
module mc_ctrl_fsm #(
   parameter logic [3:0] RESET_STATE = 4'd0,
   parameter int         CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             alu_flag,
   input  logic             alu_zero,
   output logic [4:0]       alu_op,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             ext_zero,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             illegal,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state_dbg
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  EXEC_R = 4'd2,  RWB    = 4'd3,
      EXEC_I = 4'd4,  IWB    = 4'd5,  MEMADR = 4'd6,  MEMRD  = 4'd7,
      MEMWB  = 4'd8,  MEMWR  = 4'd9,  BRANCH = 4'd10, JUMP   = 4'd11,
      TRAP   = 4'd12
   } state_t;

   typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE, BR_GTZ} br_t;

   typedef struct packed {
      logic [4:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_zero;
      logic       pc_wr;
      br_t        br;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
   } ctrl_t;

   function automatic logic [4:0] r_alu_op(input logic [5:0] f);
      case (f)
         6'h20, 6'h21: r_alu_op = 5'd1;
         6'h22, 6'h23: r_alu_op = 5'd2;
         6'h24:        r_alu_op = 5'd3;
         6'h25:        r_alu_op = 5'd4;
         6'h26:        r_alu_op = 5'd5;
         6'h27:        r_alu_op = 5'd6;
         default:      r_alu_op = 5'd0;
      endcase
   endfunction

   function automatic logic is_retire(input state_t s);
      is_retire = (s == RWB) || (s == IWB) || (s == MEMWB) || (s == MEMWR) ||
                  (s == BRANCH) || (s == JUMP);
   endfunction

   // Controls for the state being entered; IR is stable from DECODE on, so opcode/funct are safe here.
   function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op, input logic [5:0] f);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:  begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = 2'd1;
                       c.alu_op = 5'd1; c.pc_wr = 1'b1; end
         DECODE: begin c.alu_src_b = 2'd3; c.alu_op = 5'd1; end
         EXEC_R: begin c.alu_src_a = 1'b1; c.alu_op = r_alu_op(f); end
         RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'd2;
            case (op)
               6'h08, 6'h09: c.alu_op = 5'd1;
               6'h0C: begin c.alu_op = 5'd3; c.ext_zero = 1'b1; end
               6'h0D: begin c.alu_op = 5'd4; c.ext_zero = 1'b1; end
               6'h0E: begin c.alu_op = 5'd5; c.ext_zero = 1'b1; end
               default: c.alu_op = 5'd0;
            endcase
         end
         IWB:    c.reg_write = 1'b1;
         MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op = 5'd1; end
         MEMRD:  begin c.i_or_d = 1'b1; c.mem_read = 1'b1; end
         MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         MEMWR:  begin c.i_or_d = 1'b1; c.mem_write = 1'b1; end
         BRANCH: begin
            c.alu_src_a = 1'b1;
            c.pc_src    = 2'd1;
            case (op)
               6'h04:   begin c.alu_op = 5'd2; c.br = BR_EQ;  end
               6'h05:   begin c.alu_op = 5'd2; c.br = BR_NE;  end
               6'h07:   begin c.alu_op = 5'd7; c.br = BR_GTZ; end
               default: c.br = BR_NONE;
            endcase
         end
         JUMP:   begin c.pc_wr = 1'b1; c.pc_src = 2'd2; end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t           state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             illegal_q, illegal_d;
   logic             instr_done_q, instr_done_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   logic             br_taken;

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            case (opcode)
               6'h00:                             state_d = EXEC_R;
               6'h23, 6'h2B:                      state_d = MEMADR;
               6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: state_d = EXEC_I;
               6'h04, 6'h05, 6'h07:               state_d = BRANCH;
               6'h02:                             state_d = JUMP;
               default:                           state_d = TRAP;
            endcase
         end
         EXEC_R: state_d = (r_alu_op(funct) != 5'd0) ? RWB : TRAP;
         EXEC_I: state_d = IWB;
         MEMADR: state_d = (opcode == 6'h23) ? MEMRD : MEMWR;
         MEMRD:  state_d = MEMWB;
         RWB, IWB, MEMWB, MEMWR, BRANCH, JUMP: state_d = FETCH;
         default: state_d = TRAP;
      endcase
      ctrl_d        = ctrl_for(state_d, opcode, funct);
      illegal_d     = illegal_q | (state_d == TRAP);
      instr_done_d  = is_retire(state_d);
      instr_count_d = is_retire(state_q) ? instr_count_q + CNT_W'(1) : instr_count_q;
   end

   // Reset loads the reset state's own controls so the first fetch fires as soon as rst drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= state_t'(RESET_STATE);
         ctrl_q        <= ctrl_for(state_t'(RESET_STATE), 6'd0, 6'd0);
         illegal_q     <= 1'b0;
         instr_done_q  <= 1'b0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         ctrl_q        <= ctrl_d;
         illegal_q     <= illegal_d;
         instr_done_q  <= instr_done_d;
         instr_count_q <= instr_count_d;
      end
   end

   always_comb begin
      br_taken = 1'b0;
      case (ctrl_q.br)
         BR_EQ:   br_taken = alu_zero;
         BR_NE:   br_taken = !alu_zero;
         BR_GTZ:  br_taken = alu_flag;
         default: br_taken = 1'b0;
      endcase
   end

   assign alu_op      = ctrl_q.alu_op;
   assign alu_src_a   = ctrl_q.alu_src_a;
   assign alu_src_b   = ctrl_q.alu_src_b;
   assign ext_zero    = ctrl_q.ext_zero;
   assign pc_src      = ctrl_q.pc_src;
   assign i_or_d      = ctrl_q.i_or_d;
   assign reg_dst     = ctrl_q.reg_dst;
   assign mem_to_reg  = ctrl_q.mem_to_reg;
   assign pc_write    = !rst && (ctrl_q.pc_wr || br_taken);
   assign mem_read    = !rst && ctrl_q.mem_read;
   assign mem_write   = !rst && ctrl_q.mem_write;
   assign ir_write    = !rst && ctrl_q.ir_write;
   assign reg_write   = !rst && ctrl_q.reg_write;
   assign illegal     = illegal_q;
   assign instr_done  = instr_done_q;
   assign instr_count = instr_count_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: a 32-bit-counter and a 4-bit-counter build run the same stream.
module tb_mc_ctrl_fsm;
   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode, funct;
   logic        alu_flag, alu_zero;

   logic [4:0]  alu_op_a, alu_op_b;
   logic        alu_src_a_a, alu_src_a_b;
   logic [1:0]  alu_src_b_a, alu_src_b_b;
   logic        ext_zero_a, ext_zero_b, pc_write_a, pc_write_b;
   logic [1:0]  pc_src_a, pc_src_b;
   logic        i_or_d_a, i_or_d_b, mem_read_a, mem_read_b, mem_write_a, mem_write_b;
   logic        ir_write_a, ir_write_b, reg_write_a, reg_write_b, reg_dst_a, reg_dst_b;
   logic        mem_to_reg_a, mem_to_reg_b, illegal_a, illegal_b, instr_done_a, instr_done_b;
   logic [31:0] instr_count_a;
   logic [3:0]  instr_count_b;
   logic [3:0]  state_dbg_a, state_dbg_b;

   mc_ctrl_fsm dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_flag(alu_flag), .alu_zero(alu_zero),
      .alu_op(alu_op_a), .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .ext_zero(ext_zero_a),
      .pc_write(pc_write_a), .pc_src(pc_src_a), .i_or_d(i_or_d_a), .mem_read(mem_read_a),
      .mem_write(mem_write_a), .ir_write(ir_write_a), .reg_write(reg_write_a), .reg_dst(reg_dst_a),
      .mem_to_reg(mem_to_reg_a), .illegal(illegal_a), .instr_done(instr_done_a),
      .instr_count(instr_count_a), .state_dbg(state_dbg_a)
   );

   mc_ctrl_fsm #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_flag(alu_flag), .alu_zero(alu_zero),
      .alu_op(alu_op_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .ext_zero(ext_zero_b),
      .pc_write(pc_write_b), .pc_src(pc_src_b), .i_or_d(i_or_d_b), .mem_read(mem_read_b),
      .mem_write(mem_write_b), .ir_write(ir_write_b), .reg_write(reg_write_b), .reg_dst(reg_dst_b),
      .mem_to_reg(mem_to_reg_b), .illegal(illegal_b), .instr_done(instr_done_b),
      .instr_count(instr_count_b), .state_dbg(state_dbg_b)
   );

   always #5 clk = ~clk;

   // {alu_op, src_a, src_b, ext_zero, pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, instr_done}
   wire logic [19:0] ctl_a = {alu_op_a, alu_src_a_a, alu_src_b_a, ext_zero_a, pc_write_a, pc_src_a,
                              i_or_d_a, mem_read_a, mem_write_a, ir_write_a, reg_write_a, reg_dst_a,
                              mem_to_reg_a, instr_done_a};
   wire logic [19:0] ctl_b = {alu_op_b, alu_src_a_b, alu_src_b_b, ext_zero_b, pc_write_b, pc_src_b,
                              i_or_d_b, mem_read_b, mem_write_b, ir_write_b, reg_write_b, reg_dst_b,
                              mem_to_reg_b, instr_done_b};
   wire logic [4:0]  strobes_a = {pc_write_a, ir_write_a, reg_write_a, mem_read_a, mem_write_a};

   localparam logic [19:0] V_ZERO    = 20'd0;
   localparam logic [19:0] V_FETCH   = {5'd1, 1'b0, 2'd1, 1'b0, 1'b1, 2'd0, 8'b0101_0000};
   localparam logic [19:0] V_DECODE  = {5'd1, 1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 8'b0000_0000};
   localparam logic [19:0] V_EXR_ADD = {5'd1, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 8'b0000_0000};
   localparam logic [19:0] V_EXR_SUB = {5'd2, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 8'b0000_0000};
   localparam logic [19:0] V_EXR_NOR = {5'd6, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 8'b0000_0000};
   localparam logic [19:0] V_EXR_BAD = {5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 8'b0000_0000};
   localparam logic [19:0] V_RWB     = {5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'b0000_1101};
   localparam logic [19:0] V_MEMADR  = {5'd1, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 8'b0000_0000};
   localparam logic [19:0] V_MEMRD   = {5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'b1100_0000};
   localparam logic [19:0] V_MEMWB   = {5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'b0000_1011};
   localparam logic [19:0] V_MEMWR   = {5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'b1010_0001};
   localparam logic [19:0] V_BR2_T   = {5'd2, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 8'b0000_0001};
   localparam logic [19:0] V_BR2_NT  = {5'd2, 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 8'b0000_0001};
   localparam logic [19:0] V_GTZ_T   = {5'd7, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 8'b0000_0001};
   localparam logic [19:0] V_GTZ_NT  = {5'd7, 1'b1, 2'd0, 1'b0, 1'b0, 2'd1, 8'b0000_0001};
   localparam logic [19:0] V_JUMP    = {5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 8'b0000_0001};
   localparam logic [19:0] V_ORI     = {5'd4, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 8'b0000_0000};
   localparam logic [19:0] V_ADDI    = {5'd1, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 8'b0000_0000};
   localparam logic [19:0] V_ANDI    = {5'd3, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 8'b0000_0000};
   localparam logic [19:0] V_XORI    = {5'd5, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 8'b0000_0000};
   localparam logic [19:0] V_IWB     = {5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'b0000_1001};

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge with inputs set; checks both builds, then advances one cycle.
   task automatic cyc(input string tag, input logic [19:0] e);
      #1;
      chk(tag, {12'd0, ctl_a}, {12'd0, e});
      chk({tag, "/cnt4"}, {12'd0, ctl_b}, {12'd0, e});
      @(negedge clk);
   endtask

   task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic f, input int n,
                        input logic [19:0] e3, input logic [19:0] e4, input logic [19:0] e5);
      opcode = op; funct = fn; alu_zero = z; alu_flag = f;
      #1;
      chk({tag, "/fetch_state"}, {28'd0, state_dbg_a}, 32'd0);
      chk({tag, "/fetch_state4"}, {28'd0, state_dbg_b}, 32'd0);
      cyc({tag, "/c1"}, V_FETCH);
      cyc({tag, "/c2"}, V_DECODE);
      cyc({tag, "/c3"}, e3);
      if (n >= 4) cyc({tag, "/c4"}, e4);
      if (n >= 5) cyc({tag, "/c5"}, e5);
   endtask

   task automatic cnt(input string tag, input logic [31:0] exp32, input logic [3:0] exp4);
      #1;
      chk({tag, "/count"}, instr_count_a, exp32);
      chk({tag, "/count4"}, {28'd0, instr_count_b}, {28'd0, exp4});
   endtask

   initial begin
      rst = 1'b1; opcode = 6'h00; funct = 6'h00; alu_zero = 1'b0; alu_flag = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset/strobes", {27'd0, strobes_a}, 32'd0);
      chk("reset/state", {28'd0, state_dbg_a}, 32'd0);
      chk("reset/illegal", {31'd0, illegal_a}, 32'd0);
      chk("reset/done", {31'd0, instr_done_a}, 32'd0);
      cnt("reset", 32'd0, 4'd0);
      @(negedge clk);
      rst = 1'b0;

      // addi abandoned by an asynchronous reset pulse in the middle of DECODE
      opcode = 6'h08;
      cyc("addi_rst/fetch", V_FETCH);
      #1 chk("addi_rst/decode", {12'd0, ctl_a}, {12'd0, V_DECODE});
      #2 rst = 1'b1;
      #1;
      chk("arst/state", {28'd0, state_dbg_a}, 32'd0);
      chk("arst/strobes", {27'd0, strobes_a}, 32'd0);
      cnt("arst", 32'd0, 4'd0);
      @(negedge clk);
      #1 chk("arst_hold/strobes", {27'd0, strobes_a}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      instr("add", 6'h00, 6'h20, 1'b0, 1'b0, 4, V_EXR_ADD, V_RWB, V_ZERO);
      instr("sub", 6'h00, 6'h22, 1'b0, 1'b0, 4, V_EXR_SUB, V_RWB, V_ZERO);
      instr("nor", 6'h00, 6'h27, 1'b0, 1'b0, 4, V_EXR_NOR, V_RWB, V_ZERO);
      cnt("rtype", 32'd3, 4'd3);

      instr("lw", 6'h23, 6'h00, 1'b0, 1'b0, 5, V_MEMADR, V_MEMRD, V_MEMWB);
      instr("sw", 6'h2B, 6'h00, 1'b0, 1'b0, 4, V_MEMADR, V_MEMWR, V_ZERO);
      cnt("mem", 32'd5, 4'd5);

      instr("beq_z1",  6'h04, 6'h00, 1'b1, 1'b0, 3, V_BR2_T,  V_ZERO, V_ZERO);
      instr("beq_z0",  6'h04, 6'h00, 1'b0, 1'b1, 3, V_BR2_NT, V_ZERO, V_ZERO);
      instr("bne_z1",  6'h05, 6'h00, 1'b1, 1'b0, 3, V_BR2_NT, V_ZERO, V_ZERO);
      instr("bne_z0",  6'h05, 6'h00, 1'b0, 1'b0, 3, V_BR2_T,  V_ZERO, V_ZERO);
      instr("bgtz_f0", 6'h07, 6'h00, 1'b1, 1'b0, 3, V_GTZ_NT, V_ZERO, V_ZERO);
      instr("bgtz_f1", 6'h07, 6'h00, 1'b0, 1'b1, 3, V_GTZ_T,  V_ZERO, V_ZERO);
      instr("j",       6'h02, 6'h00, 1'b0, 1'b0, 3, V_JUMP,   V_ZERO, V_ZERO);
      cnt("branch", 32'd12, 4'd12);

      instr("ori",  6'h0D, 6'h00, 1'b0, 1'b0, 4, V_ORI,  V_IWB, V_ZERO);
      instr("addi", 6'h08, 6'h00, 1'b0, 1'b0, 4, V_ADDI, V_IWB, V_ZERO);
      instr("andi", 6'h0C, 6'h00, 1'b0, 1'b0, 4, V_ANDI, V_IWB, V_ZERO);
      cnt("preload", 32'd15, 4'd15);
      instr("xori", 6'h0E, 6'h00, 1'b0, 1'b0, 4, V_XORI, V_IWB, V_ZERO);
      cnt("wrap", 32'd16, 4'd0);

      // unsupported opcode: TRAP holds with no strobes until reset
      instr("op3f", 6'h3F, 6'h00, 1'b1, 1'b1, 3, V_ZERO, V_ZERO, V_ZERO);
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("trap/illegal", {31'd0, illegal_a}, 32'd1);
         chk("trap/illegal4", {31'd0, illegal_b}, 32'd1);
         chk("trap/strobes", {27'd0, strobes_a}, 32'd0);
         cyc("trap/ctl", V_ZERO);
      end
      cnt("trap", 32'd16, 4'd0);

      rst = 1'b1;
      @(negedge clk);
      #1 chk("rst2/illegal", {31'd0, illegal_a}, 32'd0);
      cnt("rst2", 32'd0, 4'd0);
      @(negedge clk);
      rst = 1'b0;

      // R-type with an unsupported funct traps after EXEC_R
      instr("jr_funct", 6'h00, 6'h08, 1'b0, 1'b0, 4, V_EXR_BAD, V_ZERO, V_ZERO);
      #1;
      chk("rbad/illegal", {31'd0, illegal_a}, 32'd1);
      chk("rbad/illegal4", {31'd0, illegal_b}, 32'd1);
      chk("rbad/state4", {28'd0, state_dbg_b}, {28'd0, state_dbg_a});
      cnt("rbad", 32'd0, 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
